// File: rtl/imem_loader.sv
// imem_loader: assembles little-endian byte pairs from a byte stream into 16-bit
// instruction-memory writes, then raises run for the fetch/execute controller.
// Ports: clk, reset (async, active high); start + n_words request a load of
// n_words 16-bit words; rx_data/rx_valid/rx_ready byte stream handshake;
// mem_we/mem_addr/mem_wdata memory write port; busy while loading; load_done
// one-cycle pulse on completion; run level after a good load; err checksum fail.
// Optional feature: define LOADER_CSUM_EN to append and verify a trailing
// checksum byte (all data bytes plus checksum must sum to 0 mod 256).
`timescale 1ns/1ps
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   n_words,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              busy,
   output logic              load_done,
   output logic              run,
   output logic              err
);
`ifdef LOADER_CSUM_EN
   typedef enum logic [2:0] {IDLE, LO, HI, WR, CSUM, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, LO, HI, WR, DONE} state_t;
`endif
   state_t state, nxt;
   logic [ADDR_W:0] n_lat, count;
   logic take, go, last, enter_done, err_n;
   always_comb begin
      rx_ready = 1'b0;
      busy = 1'b0;
      mem_we = 1'b0;
      nxt = state;
      go = start && (state == IDLE || state == DONE);
      last = (count + 1'b1) == n_lat;
      case (state)
         IDLE, DONE: if (go) nxt = (n_words == '0) ? DONE : LO;
         LO: begin
            rx_ready = 1'b1;
            busy = 1'b1;
            if (rx_valid) nxt = HI;
         end
         HI: begin
            rx_ready = 1'b1;
            busy = 1'b1;
            if (rx_valid) nxt = WR;
         end
         WR: begin
            busy = 1'b1;
            mem_we = 1'b1;
`ifdef LOADER_CSUM_EN
            nxt = last ? CSUM : LO;
`else
            nxt = last ? DONE : LO;
`endif
         end
`ifdef LOADER_CSUM_EN
         CSUM: begin
            rx_ready = 1'b1;
            busy = 1'b1;
            if (rx_valid) nxt = DONE;
         end
`endif
         default: nxt = IDLE;
      endcase
      take = rx_valid && rx_ready;
      // a restart from DONE with zero words re-enters DONE and must pulse again
      enter_done = (nxt == DONE) && (state != DONE || go);
   end
`ifdef LOADER_CSUM_EN
   logic [7:0] sum;
   logic err_q;
   assign err_n = go ? 1'b0 : (state == CSUM && take) ? (8'(sum + rx_data) != 8'd0) : err_q;
   assign err = err_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= err_n;
         if (go) sum <= '0;
         else if (take && (state == LO || state == HI)) sum <= 8'(sum + rx_data);
      end
   end
`else
   assign err_n = 1'b0;
   assign err = 1'b0;
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         n_lat <= '0;
         count <= '0;
         mem_addr <= BASE_ADDR;
         mem_wdata <= '0;
         load_done <= 1'b0;
         run <= 1'b0;
      end else begin
         state <= nxt;
         load_done <= enter_done;
         run <= enter_done ? !err_n : go ? 1'b0 : run;
         if (go) begin
            n_lat <= n_words;
            count <= '0;
            mem_addr <= BASE_ADDR;
         end else if (state == WR) begin
            count <= count + 1'b1;
            mem_addr <= mem_addr + 1'b1;
         end
         if (take && state == LO) mem_wdata[7:0] <= rx_data;
         if (take && state == HI) mem_wdata[15:8] <= rx_data;
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader; two instances (base 0x00 and 0xFF) share stimulus.
`timescale 1ns/1ps
module tb_imem_loader;
   localparam int AW = 8;
`ifdef LOADER_CSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset, start, rx_valid;
   logic [AW:0] n_words;
   logic [7:0] rx_data;
   logic rdy0, we0, busy0, done0, run0, err0;
   logic rdy1, we1, busy1, done1, run1, err1;
   logic [AW-1:0] addr0, addr1;
   logic [15:0] wd0, wd1;
   always #5 clk = ~clk;
   imem_loader #(.ADDR_W(AW), .BASE_ADDR(8'h00)) u0 (
      .clk(clk), .reset(reset), .start(start), .n_words(n_words), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
      .busy(busy0), .load_done(done0), .run(run0), .err(err0));
   imem_loader #(.ADDR_W(AW), .BASE_ADDR(8'hFF)) u1 (
      .clk(clk), .reset(reset), .start(start), .n_words(n_words), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
      .busy(busy1), .load_done(done1), .run(run1), .err(err1));
   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int we_cnt = 0;
   logic [23:0] wq0[$];
   logic [23:0] wq1[$];
   always @(negedge clk) begin
      if (we0) wq0.push_back({addr0, wd0});
      if (we1) wq1.push_back({addr1, wd1});
      we_cnt += int'(we0);
      if (done0) done_cnt++;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [7:0] neg_sum(input logic [7:0] q[$]);
      logic [7:0] s = 8'd0;
      foreach (q[i]) s = 8'(s + q[i]);
      return 8'(-s);
   endfunction
   // Drive one complete load and compare against the write list implied by the bytes.
   task automatic load(input int n, input logic [7:0] b[$], input int stall, input bit pulse,
                       input bit exp_err, input string nm);
      int q0s = wq0.size();
      int q1s = wq1.size();
      int d0 = done_cnt;
      int w0 = we_cnt;
      int idx = 0;
      int cyc = 0;
      @(negedge clk);
      start = 1'b1;
      n_words = 9'(n);
      rx_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk({nm, " busy@start"}, busy0, n > 0);
      chk({nm, " run@start"}, run0, n == 0);
      while (done_cnt == d0 && cyc < 3000) begin
         rx_valid = (idx < b.size()) && ($urandom_range(99) >= stall);
         rx_data = (idx < b.size()) ? b[idx] : 8'($urandom);
         start = pulse && busy0 && ($urandom_range(9) == 0);
         n_words = 9'($urandom);
         if (rx_valid && rdy0) idx++;
         @(negedge clk);
         cyc++;
      end
      rx_valid = 1'b0;
      start = 1'b0;
      chk({nm, " timeout"}, cyc < 3000, 1);
      @(negedge clk);
      chk({nm, " bytes used"}, idx, b.size());
      chk({nm, " write count"}, we_cnt - w0, n);
      for (int i = 0; i < n; i++) begin
         chk({nm, " wr base00"}, wq0[q0s + i], {8'(i), b[2*i+1], b[2*i]});
         chk({nm, " wr baseFF"}, wq1[q1s + i], {8'(255 + i), b[2*i+1], b[2*i]});
      end
      chk({nm, " done pulses"}, done_cnt - d0, 1);
      chk({nm, " run"}, run0, !exp_err);
      chk({nm, " err"}, err0, exp_err);
      chk({nm, " busy"}, busy0, 0);
   endtask
   typedef struct {int n; int stall; bit pulse; bit bad; int exp_we;} vec_t;
   vec_t vt[7];
   logic [7:0] bq[$];
   int s0, w0, d0;
   initial begin
      vt[0] = '{1, 0, 0, 0, 1};
      vt[1] = '{3, 30, 1, 0, 3};
      vt[2] = '{16, 50, 1, 1, 16};
      vt[3] = '{256, 10, 1, 0, 256};
      vt[4] = '{2, 70, 0, 1, 2};
      vt[5] = '{7, 0, 1, 0, 7};
      vt[6] = '{0, 0, 0, 1, 0};
      reset = 1'b1;
      start = 1'b0;
      rx_valid = 1'b0;
      n_words = '0;
      rx_data = '0;
      repeat (3) @(negedge clk);
      chk("rst rx_ready", rdy0, 0);
      chk("rst mem_we", we0, 0);
      chk("rst addr base00", addr0, 8'h00);
      chk("rst addr baseFF", addr1, 8'hFF);
      chk("rst wdata", wd0, 0);
      chk("rst busy", busy0, 0);
      chk("rst load_done", done0, 0);
      chk("rst run", run0, 0);
      chk("rst err", err0, 0);
      reset = 1'b0;
      @(negedge clk);
      // fixed four-byte load, continuous valid
      bq = '{8'h34, 8'h12, 8'hCD, 8'hAB};
      if (CS) bq.push_back(neg_sum(bq));
      s0 = wq0.size();
      load(2, bq, 0, 0, 0, "basic");
      chk("basic w0", wq0[s0], 24'h00_1234);
      chk("basic w1", wq0[s0+1], 24'h01_ABCD);
      chk("wrap w0", wq1[s0], 24'hFF_1234);
      chk("wrap w1", wq1[s0+1], 24'h00_ABCD);
      // zero-word load
      w0 = we_cnt;
      @(negedge clk);
      start = 1'b1;
      n_words = '0;
      @(negedge clk);
      start = 1'b0;
      chk("zero load_done", done0, 1);
      chk("zero run", run0, 1);
      chk("zero busy", busy0, 0);
      @(negedge clk);
      chk("zero pulse end", done0, 0);
      chk("zero run hold", run0, 1);
      chk("zero no write", we_cnt - w0, 0);
      // stall between low and high byte
      w0 = we_cnt;
      @(negedge clk);
      start = 1'b1;
      n_words = 9'd1;
      rx_valid = 1'b1;
      rx_data = 8'h5A;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (5) begin
         chk("stall busy", busy0, 1);
         chk("stall we", we0, 0);
         chk("stall ready", rdy0, 1);
         @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data = 8'hC3;
      @(negedge clk);
      rx_valid = CS;
      rx_data = 8'hE3;
      chk("stall we pulse", we0, 1);
      chk("stall wdata", wd0, 16'hC35A);
      chk("stall addr", addr0, 8'h00);
      for (int i = 0; i < 5 && !done0; i++) @(negedge clk);
      rx_valid = 1'b0;
      chk("stall done", done0, 1);
      chk("stall run", run0, 1);
      chk("stall one write", we_cnt - w0, 1);
      // reset in the middle of a load
      w0 = we_cnt;
      @(negedge clk);
      start = 1'b1;
      n_words = 9'd2;
      @(negedge clk);
      start = 1'b0;
      rx_valid = 1'b1;
      rx_data = 8'h11;
      @(negedge clk);
      rx_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("midrst busy", busy0, 0);
      chk("midrst ready", rdy0, 0);
      chk("midrst run", run0, 0);
      chk("midrst addr", addr0, 8'h00);
      chk("midrst we", we0, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) begin
         rx_valid = 1'b1;
         rx_data = 8'($urandom);
         @(negedge clk);
      end
      rx_valid = 1'b0;
      chk("midrst no write", we_cnt - w0, 0);
      chk("midrst idle", busy0, 0);
      bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      if (CS) bq.push_back(neg_sum(bq));
      s0 = wq0.size();
      load(2, bq, 20, 0, 0, "after rst");
      chk("after rst w0", wq0[s0], 24'h00_BEEF);
      chk("after rst w1", wq0[s0+1], 24'h01_DEAD);
      // checksum good / bad
      bq = '{8'h01, 8'h00};
      if (CS) bq.push_back(8'hFF);
      load(1, bq, 0, 0, 0, "csum good");
      bq = '{8'h01, 8'h00};
      if (CS) bq.push_back(8'h00);
      load(1, bq, 0, 0, CS, "csum bad");
      // randomized loads from the vector table
      foreach (vt[k]) begin
         bq.delete();
         for (int i = 0; i < 2 * vt[k].n; i++) bq.push_back(8'($urandom));
         if (CS && vt[k].n > 0)
            bq.push_back(vt[k].bad ? neg_sum(bq) ^ 8'(1 + $urandom_range(254)) : neg_sum(bq));
         w0 = we_cnt;
         load(vt[k].n, bq, vt[k].stall, vt[k].pulse, CS && vt[k].bad && vt[k].n > 0, $sformatf("vec%0d", k));
         chk($sformatf("vec%0d table writes", k), we_cnt - w0, vt[k].exp_we);
      end
      d0 = done_cnt;
      repeat (4) @(negedge clk);
      chk("quiet no pulse", done_cnt - d0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first word address written.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 n_words  input  ADDR_W+1  number of 16-bit words to load, sampled on accepted start; legal range 0..2^ADDR_W.
REQ-007 rx_data  input  8  incoming program byte.
REQ-008 rx_valid  input  1  rx_data valid.
REQ-009 rx_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  instruction-memory write strobe.
REQ-011 mem_addr  output  ADDR_W  write address.
REQ-012 mem_wdata  output  16  write data.
REQ-013 busy  output  1  load in progress.
REQ-014 load_done  output  1  one-cycle pulse at end of load.
REQ-015 run  output  1  level enabling the downstream fetch/execute controller.
REQ-016 err  output  1  last load failed its checksum (0 when LOADER_CSUM_EN is undefined).

Function
REQ-017 SHALL implement states IDLE, LO, HI, WR, CSUM, DONE.
REQ-018 IDLE/DONE + start: latch n_words, set word count 0, mem_addr = BASE_ADDR, run=0, err=0; go LO, or DONE if n_words==0.
REQ-019 start in LO, HI, WR, CSUM SHALL be ignored.
REQ-020 Byte transfer occurs only on a cycle with rx_valid && rx_ready; rx_ready=1 only in LO, HI, CSUM.
REQ-021 LO: accepted byte -> low half of word; go HI.
REQ-022 HI: accepted byte -> high half; go WR.
REQ-023 WR: mem_we=1 for exactly one cycle with assembled mem_wdata and current mem_addr (write one cycle after high byte accepted).
REQ-024 After WR: mem_addr increments modulo 2^ADDR_W (wraps); count increments; if count==n_words go CSUM (macro defined) or DONE, else LO.
REQ-025 Entering DONE: load_done pulses one cycle; run=1 unless err=1.
REQ-026 run SHALL hold high in DONE until next accepted start or reset.
REQ-027 busy=1 in LO, HI, WR, CSUM; 0 otherwise.
REQ-028 mem_we=0 in all states except WR.
REQ-029 rx_valid stalls SHALL hold the state indefinitely without output change.

Reset
REQ-030 reset SHALL force state IDLE immediately, regardless of clock.
REQ-031 Reset values: rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, load_done=0, run=0, err=0, count=0, checksum=0.
REQ-032 Reset mid-load SHALL abandon the load; no further memory writes until a new start.

Configuration
REQ-033 Macro LOADER_CSUM_EN defined: 8-bit running sum of all data bytes kept; CSUM state accepts one extra byte; err=1 if (sum+byte) mod 256 != 0; then DONE.
REQ-034 LOADER_CSUM_EN undefined: no CSUM state, no checksum logic; err tied 0; last WR goes directly to DONE.

Verification
REQ-035 reset, start, n_words=2, bytes 34 12 CD AB (rx_valid always 1) -> writes 0x1234@0x00, 0xABCD@0x01, load_done pulse, run=1.
REQ-036 start, n_words=0 -> DONE next cycle, load_done pulse, run=1, mem_we never asserted.
REQ-037 BASE_ADDR=0xFF, n_words=2 -> writes at 0xFF then 0x00 (wrap).
REQ-038 rx_valid low 5 cycles between LO and HI bytes -> state held, single correct write, no extra mem_we.
REQ-039 reset asserted after first byte of word 1 -> immediate IDLE, run=0, no write; new start loads correctly.
REQ-040 LOADER_CSUM_EN: bytes 01 00, csum FF -> err=0, run=1; csum 00 -> err=1, run=0, load_done still pulses.
